datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//  Single-issue controller that sequences the 8x16 register-file + ALU datapath.
//  Accepts one instruction per valid/ready handshake, drives the datapath control ports
//  (WE, W1, num_R1, num_R2, MS, Din), and writes the ALU result back into the register file.
//  Returns a result/status via a valid/ready response port. Sits between the host/testbench and Datapath.
// PARAMETERS
//  size_data  16  datapath word width; also immediate and result width
//  CNT_W      16  width of the completed-instruction counter
// PORTS
//  CLK          in   1             clock, all state on rising edge
//  RST          in   1             reset, asynchronous, active-high
//  instr_valid  in   1             instruction offered
//  instr_ready  out  1             sequencer can accept (high only in IDLE)
//  instr        in   size_data+16  [D+15:D+14] op, [D+13:D+11] rd, [D+10:D+8] rs1, [D+7:D+5] rs2,
//                                  [D+4:D+2] ms, [D+1:D] reserved, [D-1:0] imm  (D=size_data)
//  resp_valid   out  1             response available
//  resp_ready   in   1             response consumed
//  resp_data    out  size_data     result (ALU result / imm written / 0 for NOP or illegal)
//  resp_err     out  1             1 = illegal opcode
//  busy         out  1             ~IDLE
//  op_count     out  CNT_W         completed responses (incl. illegal), wraps at 2^CNT_W
//  dp_WE        out  1             to Datapath WE
//  dp_W1        out  3             to Datapath W1
//  dp_num_R1    out  3             to Datapath num_R1
//  dp_num_R2    out  3             to Datapath num_R2
//  dp_MS        out  3             to Datapath MS
//  dp_Din       out  size_data     to Datapath Din
//  dp_ALU_out   in   size_data     from Datapath ALU_out (combinational read path)
// BEHAVIOUR
//  - Opcodes: 00 NOP, 01 LOAD (reg[rd]<=imm), 10 ALU (reg[rd]<=ALU(reg[rs1],reg[rs2],ms)), 11 illegal.
//  - FSM states: IDLE, WR_IMM, EXEC, WB, RESP. Instruction fields latched on accept.
//  - IDLE: instr_ready=1; on instr_valid: op01->WR_IMM, op10->EXEC, op00/op11->RESP.
//  - WR_IMM (1 cyc): dp_WE=1, dp_W1=rd, dp_Din=imm; result_q<=imm; ->RESP.
//  - EXEC (1 cyc): dp_num_R1=rs1, dp_num_R2=rs2, dp_MS=ms, dp_WE=0; result_q<=dp_ALU_out at edge; ->WB.
//  - WB (1 cyc): dp_WE=1, dp_W1=rd, dp_Din=result_q; dp_num_R1/R2/MS held; ->RESP.
//  - RESP: resp_valid=1, resp_data=result_q, resp_err set only for op11; held stable until resp_ready;
//    on resp_valid&resp_ready: op_count++ and ->IDLE same edge.
//  - Latency (accept edge = T): LOAD WE in T+1, resp_valid T+2; ALU read T+1, WE T+2, resp_valid T+3;
//    NOP/illegal resp_valid T+1. Min spacing: LOAD 3, ALU 4, NOP 2 cycles.
//  - dp_WE is 1 only in WR_IMM and WB; exactly one write per LOAD/ALU, none for NOP/illegal.
//  - rd==rs1/rs2 legal: operands captured in EXEC before WB write.
//  - Outputs decoded from state + latched fields only (Moore); no comb path instr->dp_*.
//  - Reset (any state): state=IDLE, result_q=0, op_count=0, all dp_* =0, resp_valid=0, resp_err=0,
//    busy=0, instr_ready=1 after release; in-flight instruction dropped, no write after release.
//  - op_count wraps 2^CNT_W-1 -> 0.
// TESTING
//  1 LOAD rd=1 imm=0x0005 -> dp_WE=1,W1=1,Din=0x0005 at T+1; resp_data=0x0005,err=0 at T+2.
//  2 LOAD R1=5,R2=3; ALU rd=3 rs1=1 rs2=2 ms=ADD code -> WE at T+2 W1=3 Din=0x0008; resp_data=0x0008.
//  3 ALU rd=1 rs1=1 rs2=1 ms=ADD with R1=0x7 -> R1=0x000E, resp 0x000E (rd aliasing).
//  4 op=11 -> no dp_WE, resp_err=1, resp_data=0; hold resp_ready=0 5 cycles -> resp stable, instr_ready=0.
//  5 RST asserted during WB of ALU -> dp_WE drops immediately, no write; op_count=0, IDLE next.
//  6 CNT_W=4, 16 NOPs -> op_count returns to 0; back-to-back NOPs with resp_ready=1 every 2 cycles.

Source files
------------

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - single-issue sequencer driving the 8x16 register-file + ALU datapath
module datapath_sequencer #(
  parameter int size_data = 16,
  parameter int CNT_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [size_data+15:0] instr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [size_data-1:0]  resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count,
  output logic                  dp_WE,
  output logic [2:0]            dp_W1,
  output logic [2:0]            dp_num_R1,
  output logic [2:0]            dp_num_R2,
  output logic [2:0]            dp_MS,
  output logic [size_data-1:0]  dp_Din,
  input  logic [size_data-1:0]  dp_ALU_out
);
  localparam int D = size_data;

  typedef enum logic [2:0] {S_IDLE, S_WR_IMM, S_EXEC, S_WB, S_RESP} state_t;

  logic [1:0]   op_w;
  logic [2:0]   rd_w, rs1_w, rs2_w, ms_w;
  logic [D-1:0] imm_w;
  logic         unused_rsvd;

  assign op_w        = instr[D+15:D+14];
  assign rd_w        = instr[D+13:D+11];
  assign rs1_w       = instr[D+10:D+8];
  assign rs2_w       = instr[D+7:D+5];
  assign ms_w        = instr[D+4:D+2];
  assign imm_w       = instr[D-1:0];
  assign unused_rsvd = ^instr[D+1:D];

  state_t       state_q;
  logic [2:0]   rd_q;
  logic [D-1:0] imm_q;
  logic [D-1:0] result_q;
  logic         err_q;
  logic [CNT_W-1:0] cnt_q;
  logic         we_q;
  logic [2:0]   w1_q, r1_q, r2_q, ms_q;
  logic [D-1:0] din_q;

  // Datapath controls are registered on entry to each state so they depend on state only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      w1_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      ms_q     <= '0;
      din_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            rd_q  <= rd_w;
            imm_q <= imm_w;
            err_q <= 1'b0;
            case (op_w)
              2'b01: begin
                we_q    <= 1'b1;
                w1_q    <= rd_w;
                din_q   <= imm_w;
                state_q <= S_WR_IMM;
              end
              2'b10: begin
                r1_q    <= rs1_w;
                r2_q    <= rs2_w;
                ms_q    <= ms_w;
                state_q <= S_EXEC;
              end
              2'b11: begin
                result_q <= '0;
                err_q    <= 1'b1;
                state_q  <= S_RESP;
              end
              default: begin
                result_q <= '0;
                state_q  <= S_RESP;
              end
            endcase
          end
        end
        S_WR_IMM: begin
          result_q <= imm_q;
          we_q     <= 1'b0;
          w1_q     <= '0;
          din_q    <= '0;
          state_q  <= S_RESP;
        end
        S_EXEC: begin
          // Operands are read here, before the WB write, so rd may alias rs1/rs2.
          result_q <= dp_ALU_out;
          we_q     <= 1'b1;
          w1_q     <= rd_q;
          din_q    <= dp_ALU_out;
          state_q  <= S_WB;
        end
        S_WB: begin
          we_q    <= 1'b0;
          w1_q    <= '0;
          din_q   <= '0;
          r1_q    <= '0;
          r2_q    <= '0;
          ms_q    <= '0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = result_q;
  assign resp_err    = err_q;
  assign op_count    = cnt_q;
  assign dp_WE       = we_q;
  assign dp_W1       = w1_q;
  assign dp_num_R1   = r1_q;
  assign dp_num_R2   = r2_q;
  assign dp_MS       = ms_q;
  assign dp_Din      = din_q;

endmodule
